// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage.
//   XLEN       : architectural register / address width
//   INST_BYTES : bytes per instruction word (PC increment)
//   NOP        : canonical ADDI x0,x0,0 encoding
//   fetch_state_e : fetch control states (FETCH, DRAIN)
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,  // normal operation, every response is kept
    DRAIN = 1'b1   // stale responses from before a redirect are still owed
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush.
//   Clk, Reset : clock, synchronous active-high reset (also clears storage)
//   push/din   : write din when not full (or when full and popping)
//   pop/dout   : dout is the registered head entry; pop advances it
//   flush      : discard all entries (storage contents left as-is)
//   full/empty/count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage.
//   Clk, Reset        : clock, synchronous active-high reset
//   Redirect(_PC)     : one-cycle redirect pulse and new target (bits [1:0] ignored)
//   Imem_Req_*        : word fetch request channel (valid/ready), Imem_Addr = PC
//   Imem_Resp_*       : in-order instruction responses, never back-pressured
//   Inst_Valid/Ready  : decode handshake; Inst/Inst_PC are the buffer head
// Requests are only issued while a buffer slot is guaranteed for the reply
// (outstanding + occupancy < BUF_DEPTH). A redirect flushes the buffer and the
// tag queue and converts every still-owed response into one to be dropped.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_PC,
  output logic            Imem_Req_Valid,
  input  logic            Imem_Req_Ready,
  output logic [XLEN-1:0] Imem_Addr,
  input  logic            Imem_Resp_Valid,
  input  logic [XLEN-1:0] Imem_Resp_Data,
  output logic            Inst_Valid,
  input  logic            Inst_Ready,
  output logic [XLEN-1:0] Inst,
  output logic [XLEN-1:0] Inst_PC
);

  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(BUF_DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding, out_nxt;
  logic [CW-1:0]   drop, drop_nxt;
  logic [CW-1:0]   occ, tag_count;
  logic            accept, resp, draining, keep, pop_inst;
  logic            buf_full, buf_empty, tag_full, tag_empty;
  logic [2*XLEN-1:0] buf_head;
  logic [XLEN-1:0] tag_head;
  logic            unused_bits;

  assign draining = (state == DRAIN);

  assign Imem_Req_Valid = !Reset && (({1'b0, outstanding} + {1'b0, occ}) < DEPTH_C);
  assign Imem_Addr      = pc;
  assign accept         = Imem_Req_Valid && Imem_Req_Ready;
  assign resp           = Imem_Resp_Valid && !Reset;

  // Responses are kept only outside a drain and never in a redirect cycle;
  // both cases are already included in the drop accounting below.
  assign keep = resp && !draining && !Redirect;

  assign Inst_Valid = !Reset && !buf_empty;
  assign pop_inst   = Inst_Valid && Inst_Ready;
  assign Inst       = Reset ? '0 : buf_head[2*XLEN-1:XLEN];
  assign Inst_PC    = Reset ? '0 : buf_head[XLEN-1:0];

  // Every response retires one outstanding request, dropped or kept.
  always_comb begin
    out_nxt = outstanding + CW'(accept) - CW'(resp);
  end

  // On redirect every response still owed after this cycle becomes stale,
  // including one for a request accepted in the redirect cycle itself.
  always_comb begin
    drop_nxt = drop;
    if (Redirect)
      drop_nxt = out_nxt;
    else if (resp && draining)
      drop_nxt = drop - CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      state       <= FETCH;
    end else begin
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      if (Redirect)
        pc <= {Redirect_PC[XLEN-1:2], 2'b00};
      else if (accept)
        pc <= pc_next(pc);
      case (state)
        FETCH:   if (drop_nxt != '0) state <= DRAIN;
        DRAIN:   if (drop_nxt == '0) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // PC of each in-flight, non-stale request, matched to its response in order.
  sync_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (XLEN)
  ) u_tag_q (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (accept),
    .pop   (keep),
    .flush (Redirect),
    .din   (pc),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Instruction buffer holding {instruction, PC} pairs for decode.
  sync_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2*XLEN)
  ) u_inst_buf (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (keep),
    .pop   (pop_inst),
    .flush (Redirect),
    .din   ({Imem_Resp_Data, tag_head}),
    .dout  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (occ)
  );

  // Status bits not needed by the credit scheme.
  assign unused_bits = ^{Redirect_PC[1:0], buf_full, tag_full, tag_empty, tag_count};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        Clk = 1'b0;
  logic        Reset, Redirect, Imem_Req_Valid, Imem_Req_Ready;
  logic        Imem_Resp_Valid, Inst_Valid, Inst_Ready;
  logic [31:0] Redirect_PC, Imem_Addr, Imem_Resp_Data, Inst, Inst_PC;

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .Imem_Req_Valid(Imem_Req_Valid), .Imem_Req_Ready(Imem_Req_Ready), .Imem_Addr(Imem_Addr),
    .Imem_Resp_Valid(Imem_Resp_Valid), .Imem_Resp_Data(Imem_Resp_Data),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst(Inst), .Inst_PC(Inst_PC)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] target; logic [31:0] addr0; logic [31:0] addr1; } redir_vec_t;

  mreq_t       mq[$];          // memory model: accepted requests awaiting a reply
  logic [31:0] acc_log[$], dec_log[$];
  redir_vec_t  vt[5];

  int          nvec = 0, nerr = 0, cyc = 0;
  int          acc_cnt = 0, dec_cnt = 0, resp_cnt = 0;
  int unsigned ready_pct = 100, resp_pct = 100, lat_min = 1, lat_max = 1;
  bit          rand_ready = 0;
  bit          s_acc, s_dec, s_resp, s_valid;
  logic [31:0] exp_req, exp_pc;   // reference model: next request / next decoded PC

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic qchk(input string name, input logic [31:0] q[$], input int idx,
                      input logic [31:0] want);
    if (idx < q.size()) chk(name, q[idx], want);
    else begin
      nvec++; nerr++;
      $display("FAIL %s: got <none> expected %h (cycle %0d)", name, want, cyc);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic redir, input logic [31:0] rpc);
    Redirect    = redir;
    Redirect_PC = rpc;
    if (rand_ready) Inst_Ready = ($urandom_range(99) < 60);
    Imem_Req_Ready = ($urandom_range(99) < ready_pct);
    s_resp = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < resp_pct);
    Imem_Resp_Valid = s_resp;
    Imem_Resp_Data  = s_resp ? memfn(mq[0].addr) : $urandom;
    #1;
    s_acc   = Imem_Req_Valid && Imem_Req_Ready;
    s_dec   = Inst_Valid && Inst_Ready;
    s_valid = Inst_Valid;
    if (Reset) begin
      chk("rst_req_valid", 32'(Imem_Req_Valid), 0);
      chk("rst_inst_valid", 32'(Inst_Valid), 0);
      exp_req = RST_PC;
      exp_pc  = RST_PC;
    end else begin
      if (s_acc) begin
        chk("req_addr", Imem_Addr, exp_req);
        exp_req += 4;
        acc_log.push_back(Imem_Addr);
        acc_cnt++;
      end
      if (s_dec) begin
        chk("inst_pc", Inst_PC, exp_pc);
        chk("inst_data", Inst, memfn(exp_pc));
        exp_pc += 4;
        dec_log.push_back(Inst_PC);
        dec_cnt++;
      end
      if (redir) begin
        exp_req = {rpc[31:2], 2'b00};
        exp_pc  = exp_req;
      end
    end
    if (s_resp) begin mq.delete(0); resp_cnt++; end
    if (s_acc) mq.push_back('{addr: Imem_Addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    Redirect = 1'b0;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) step(1'b0, 32'h0);
    mq.delete();
    Reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc, first_v, c;
    vt[0] = '{32'h0000_1003, 32'h0000_1000, 32'h0000_1004};
    vt[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};
    vt[4] = '{32'h0000_0FFF, 32'h0000_0FFC, 32'h0000_1000};

    Reset = 1'b1; Redirect = 1'b0; Redirect_PC = '0; Imem_Req_Ready = 1'b0;
    Imem_Resp_Valid = 1'b0; Imem_Resp_Data = '0; Inst_Ready = 1'b1;
    @(negedge Clk);

    // Reset state and first fetches, 1-cycle memory, decode always ready.
    do_reset(3);
    #1;
    chk("rst_inst", Inst, 32'h0);
    chk("rst_inst_pc", Inst_PC, 32'h0);
    chk("rst_addr", Imem_Addr, RST_PC);
    chk("rel_req_valid", 32'(Imem_Req_Valid), 1);
    acc_log.delete(); dec_log.delete(); dec_cnt = 0;
    first_acc = -1; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      c = cyc;
      step(1'b0, 32'h0);
      if (first_acc < 0 && s_acc) first_acc = c;
      if (first_v < 0 && s_valid) first_v = c;
    end
    chk("fill_latency", 32'(first_v - first_acc), 2);
    qchk("seq_addr0", acc_log, 0, 32'h0);
    qchk("seq_addr1", acc_log, 1, 32'h4);
    qchk("seq_addr2", acc_log, 2, 32'h8);
    qchk("seq_pc2", dec_log, 2, 32'h8);
    chk("seq_progress", 32'(dec_cnt >= 8), 1);

    // Decode stalled: exactly DEPTH requests, then the credit closes.
    Inst_Ready = 1'b0;
    do_reset(2);
    acc_cnt = 0;
    repeat (10) step(1'b0, 32'h0);
    chk("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
    chk("stall_req_valid", 32'(Imem_Req_Valid), 0);
    chk("stall_inst_valid", 32'(Inst_Valid), 1);
    Inst_Ready = 1'b1;
    dec_log.delete();
    repeat (20) step(1'b0, 32'h0);
    qchk("resume_pc0", dec_log, 0, 32'h0);
    qchk("resume_pc1", dec_log, 1, 32'h4);
    chk("resume_progress", 32'(dec_log.size() >= 8), 1);

    // Redirect with two responses owed.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    acc_cnt = 0;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("owed_two", 32'(acc_cnt), 2);
    step(1'b1, 32'h0000_1003);
    chk("redir_next_addr", Imem_Addr, 32'h0000_1000);
    acc_log.delete(); dec_log.delete();
    repeat (25) step(1'b0, 32'h0);
    qchk("redir_addr0", acc_log, 0, 32'h0000_1000);
    qchk("redir_pc0", dec_log, 0, 32'h0000_1000);

    // Redirect coinciding with a response and a decode handshake.
    lat_min = 1; lat_max = 1;
    do_reset(2);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    dec_log.delete();
    step(1'b1, 32'h0000_0200);
    chk("coinc_resp", 32'(s_resp), 1);
    chk("coinc_dec", 32'(s_dec), 1);
    qchk("coinc_dec_pc", dec_log, 0, 32'h0);
    chk("coinc_flushed", 32'(Inst_Valid), 0);
    dec_log.delete();
    repeat (15) step(1'b0, 32'h0);
    qchk("coinc_next_pc", dec_log, 0, 32'h0000_0200);

    // Table of redirect targets: alignment masking and PC wrap.
    for (int v = 0; v < 5; v++) begin
      step(1'b1, vt[v].target);
      acc_log.delete(); dec_log.delete();
      repeat (20) step(1'b0, 32'h0);
      qchk($sformatf("tbl%0d_addr0", v), acc_log, 0, vt[v].addr0);
      qchk($sformatf("tbl%0d_addr1", v), acc_log, 1, vt[v].addr1);
      qchk($sformatf("tbl%0d_pc0", v), dec_log, 0, vt[v].addr0);
      qchk($sformatf("tbl%0d_pc1", v), dec_log, 1, vt[v].addr1);
    end

    // Back-to-back redirects with requests in flight.
    lat_min = 2; lat_max = 2;
    repeat (3) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_3000);
    step(1'b1, 32'h0000_4000);
    dec_log.delete();
    repeat (25) step(1'b0, 32'h0);
    qchk("b2b_pc0", dec_log, 0, 32'h0000_4000);

    // Reset mid-stream with responses still arriving during reset.
    lat_min = 3; lat_max = 3;
    repeat (5) step(1'b0, 32'h0);
    Reset = 1'b1;
    resp_cnt = 0;
    step(1'b0, 32'h0);
    chk("mid_rst_addr", Imem_Addr, RST_PC);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("mid_rst_late_resp", 32'(resp_cnt > 0), 1);
    mq.delete();
    Reset = 1'b0;
    dec_log.delete();
    repeat (25) step(1'b0, 32'h0);
    qchk("mid_rst_pc0", dec_log, 0, RST_PC);

    // Randomized traffic against the stream model.
    ready_pct = 70; resp_pct = 75; lat_min = 1; lat_max = 4; rand_ready = 1;
    dec_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4)
        step(1'b1, ($urandom_range(4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
      else
        step(1'b0, 32'h0);
    end
    chk("rand_progress", 32'(dec_cnt >= 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- RV32I instruction fetch stage.
- Consumes the program counter. It owns the PC state, issues word reads to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers the returned instructions and presents (instruction, PC) pairs to decode over a valid/ready channel.
- Handles branch/jump redirects, which flush everything in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Redirect  input  1  one-cycle pulse; replaces the PC and flushes.
- Redirect_PC  input  32  new fetch target; bits [1:0] ignored (treated as 0).
- Imem_Req_Valid  output  1  fetch request valid.
- Imem_Req_Ready  input  1  memory accepts the request this cycle.
- Imem_Addr  output  32  word address of the request; bits [1:0] always 0.
- Imem_Resp_Valid  input  1  response data valid.
- Imem_Resp_Data  input  32  instruction word.
- Inst_Valid  output  1  buffer head valid toward decode.
- Inst_Ready  input  1  decode accepts the head this cycle.
- Inst  output  32  instruction at buffer head.
- Inst_PC  output  32  PC of Inst.

Behaviour:
- Reset (synchronous, active-high, any cycle, overrides everything else in the same cycle):
  - PC <= RESET_PC.
  - Buffer emptied; outstanding count = 0; drop count = 0.
  - Imem_Req_Valid = 0 and Inst_Valid = 0 while Reset is high.
  - Inst, Inst_PC = 0.
  - Responses arriving during reset are discarded.
- Credit rule:
  - Imem_Req_Valid = !Reset && (outstanding + occupancy < BUF_DEPTH).
  - Imem_Addr = PC.
  - This guarantees a buffer slot for every accepted request, so a response is never back-pressured.
- Request accept (Imem_Req_Valid && Imem_Req_Ready):
  - PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - outstanding += 1.
  - The request's PC is pushed into a BUF_DEPTH-entry tag queue.
- Memory contract: responses are in order, at most one per cycle, and arrive at least one cycle after the accept. A same-cycle accept and response are both applied.
- Response:
  - If drop count > 0: discard the response, drop -= 1, outstanding -= 1.
  - Otherwise: write {data, tag-queue head PC} into the buffer, outstanding -= 1.
- Decode handshake:
  - Inst_Valid = buffer non-empty.
  - Inst and Inst_PC come from registers driven by the buffer head.
  - On Inst_Valid && Inst_Ready: pop the head.
  - Fill-through: an empty buffer plus a response gives Inst_Valid=1 on the next cycle (fetch latency = memory latency + 1).
  - Push and pop in the same cycle with the buffer full is legal.
- Redirect (if Reset is low):
  - PC <= {Redirect_PC[31:2], 2'b00}.
  - Buffer and tag queue cleared; Inst_Valid = 0 next cycle.
  - drop <= outstanding after this cycle's updates, i.e. responses still owed, including any request accepted this same cycle.
  - A response arriving in the redirect cycle is discarded and counted.
  - A decode handshake in the redirect cycle completes (decode keeps that instruction).
  - Imem_Req_Valid may drop or change address on a redirect even if the request was not yet accepted; the memory treats an unaccepted request as withdrawn.
  - Back-to-back redirects: each reloads the PC; the drop counts accumulate correctly.
- Request stability: apart from redirect, a valid request holds Imem_Addr stable until Imem_Req_Ready.
- Control is a 2-state FSM:
  - FETCH: normal operation.
  - DRAIN: drop > 0. New requests are still issued; only stale responses are discarded.
  - DRAIN -> FETCH when drop reaches 0.

Decomposition:
- Shared package rv32i_pkg: XLEN=32, INST_BYTES=4, NOP instruction 32'h0000_0013, fetch state enum (FETCH, DRAIN).
- One sub-module, sync_fifo (DEPTH, WIDTH=64, Clk, Reset, push/pop/flush, full/empty/count).
  - Instantiated twice: instruction buffer (data+PC) and tag queue (PC, WIDTH=32).

Test Plan:
- Reset then release, memory always ready, 1-cycle response latency, Inst_Ready=1 -> Imem_Addr sequence 0x0, 0x4, 0x8, and so on; Inst_PC follows the same sequence with correct data; Inst_Valid first high 2 cycles after the first accept.
- Inst_Ready=0 for 10 cycles -> exactly BUF_DEPTH accepts, then Imem_Req_Valid=0; no response lost; the stream resumes in order when Inst_Ready=1.
- Redirect to 0x0000_1003 with 2 responses outstanding -> the next request address is 0x0000_1000; both stale responses are dropped; the first Inst_PC after the redirect is 0x1000.
- Redirect in the same cycle as a response and a decode handshake -> the handshake instruction is consumed, the response is discarded, and the buffer is empty next cycle.
- PC at 0xFFFF_FFFC, request accepted -> the next Imem_Addr is 0x0000_0000.
- Reset asserted mid-stream with requests outstanding -> Imem_Addr = RESET_PC, Inst_Valid = 0; late responses during reset are ignored; fetch restarts cleanly.
